// File: rtl/sseg_pkg.sv
//------------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the seven-segment scan controller:
//   SEG_BLANK    - all segments off (active-low), dp off
//   SEG_TABLE    - hex nibble to {dp,g,f,e,d,c,b,a} active-low pattern
//   scan_state_e - scan FSM states
//------------------------------------------------------------------------------
package sseg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Index 0 is the rightmost element of the concatenation.
   localparam logic [15:0][7:0] SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   typedef enum logic [1:0] {
      IDLE,
      DEAD,
      DRIVE
   } scan_state_e;

endpackage

// File: rtl/sseg_decode.sv
//------------------------------------------------------------------------------
// sseg_decode
// Combinational hex-to-segment decoder with blanking.
//   nibble : hex digit to show
//   blank  : 1 forces all segments off
//   seg    : active-low {dp,g,f,e,d,c,b,a}; dp always off
//------------------------------------------------------------------------------
module sseg_decode
   import sseg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [7:0] seg
);

   assign seg = blank ? SEG_BLANK : SEG_TABLE[nibble];

endmodule

// File: rtl/sseg_scan_ctrl.sv
//------------------------------------------------------------------------------
// sseg_scan_ctrl
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits on a
// shared segment bus. Each digit gets DEAD_CYCLES of full blanking followed
// by PRESCALE cycles of drive. New values arrive through a one-deep pending
// register and are committed to the displayed shadow only at frame start.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            scan enable; low forces the display dark
//   load_valid/ready  handshake for load_data
//   load_data         NUM_DIGITS hex nibbles, [3:0] = digit 0 (rightmost)
//   blank_mask        bit i = 1 blanks digit i (sampled at slot start)
//   seg_out           active-low segments {dp,g,f,e,d,c,b,a}
//   an_out            active-low anode selects, at most one low
//   frame_done        one-cycle pulse when a full scan completes
//
// Build option: define SSEG_LEADING_ZERO_BLANK_EN to blank digits above the
// highest nonzero nibble (digit 0 is always shown).
//------------------------------------------------------------------------------
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int PRESCALE    = 50000,
   parameter int DEAD_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_done
);

   localparam int CNT_MAX = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   scan_state_e                  state, state_nxt;
   logic [IDX_W-1:0]             idx, idx_nxt;
   logic [CNT_W-1:0]             cnt, cnt_nxt;
   logic [NUM_DIGITS-1:0][3:0]   shadow, pending;
   logic                         frame_start, wrap;
   logic                         xfer, commit;
   logic [NUM_DIGITS-1:0]        lz_mask;
   logic [7:0]                   dec_seg, seg_nxt;
   logic [NUM_DIGITS-1:0]        an_nxt;

   //---------------------------------------------------------------------------
   // Leading-zero blanking mask
   //---------------------------------------------------------------------------
`ifdef SSEG_LEADING_ZERO_BLANK_EN
   always_comb begin : lz_calc
      logic seen;
      seen    = 1'b0;
      lz_mask = '0;
      // Walk down from the top digit; everything above the first nonzero
      // nibble is blanked. Digit 0 is never touched.
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (shadow[i] != 4'h0) seen = 1'b1;
         lz_mask[i] = ~seen;
      end
   end
`else
   assign lz_mask = '0;
`endif

   // One decoder on the currently selected digit. Shadow and idx are stable
   // across DEAD->DRIVE, so this is the pattern for the slot being entered.
   sseg_decode u_decode (
      .nibble (shadow[idx]),
      .blank  (blank_mask[idx] | lz_mask[idx]),
      .seg    (dec_seg)
   );

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   // NOTE: every output of this block gets a default first so no path leaves
   // a variable unassigned, which would infer a latch.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      cnt_nxt     = cnt + 1'b1;
      frame_start = 1'b0;
      wrap        = 1'b0;

      if (!enable) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         cnt_nxt   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_nxt   = DEAD;
               idx_nxt     = '0;
               cnt_nxt     = '0;
               frame_start = 1'b1;
            end
            DEAD: begin
               if (cnt == DEAD_LAST) begin
                  state_nxt = DRIVE;
                  cnt_nxt   = '0;
               end
            end
            DRIVE: begin
               if (cnt == DRIVE_LAST) begin
                  state_nxt = DEAD;
                  cnt_nxt   = '0;
                  if (idx == IDX_LAST) begin
                     idx_nxt     = '0;
                     wrap        = 1'b1;
                     frame_start = 1'b1;
                  end else begin
                     idx_nxt = idx + 1'b1;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               idx_nxt   = '0;
               cnt_nxt   = '0;
            end
         endcase
      end

      // Outputs are registered from next-state values so they line up with
      // the state register. The segment pattern is latched on DRIVE entry and
      // held, which also freezes the blank_mask sample for the slot.
      an_nxt = '1;
      if (state_nxt == DRIVE) an_nxt[idx_nxt] = 1'b0;

      if (state_nxt != DRIVE) seg_nxt = SEG_BLANK;
      else if (state != DRIVE) seg_nxt = dec_seg;
      else seg_nxt = seg_out;
   end

   // Pending is full exactly when load_ready is low.
   assign xfer   = load_valid && load_ready;
   assign commit = !load_ready && (frame_start || state == IDLE);

   //---------------------------------------------------------------------------
   // Registers
   //---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         shadow     <= '0;
         pending    <= '0;
         load_ready <= 1'b1;
         seg_out    <= SEG_BLANK;
         an_out     <= '1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         seg_out    <= seg_nxt;
         an_out     <= an_nxt;
         frame_done <= wrap;
         if (commit) shadow  <= pending;
         if (xfer)   pending <= load_data;
         // A transfer on a commit cycle refills pending with the new data.
         if (xfer)        load_ready <= 1'b0;
         else if (commit) load_ready <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
//------------------------------------------------------------------------------
// tb_sseg_scan_ctrl
// Self-checking bench for sseg_scan_ctrl with NUM_DIGITS=4, PRESCALE=4,
// DEAD_CYCLES=2. A timeline model predicts every output cycle; predictions
// are queued at each clock edge and compared shortly after it.
//------------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

   localparam int ND    = 4;
   localparam int PS    = 4;
   localparam int DC    = 2;
   localparam int SLOT  = PS + DC;
   localparam int FRAME = ND * SLOT;

   logic            clk;
   logic            rst_n;
   logic            enable;
   logic            load_valid;
   logic            load_ready;
   logic [4*ND-1:0] load_data;
   logic [ND-1:0]   blank_mask;
   logic [7:0]      seg_out;
   logic [ND-1:0]   an_out;
   logic            frame_done;

   sseg_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .PRESCALE    (PS),
      .DEAD_CYCLES (DC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .blank_mask (blank_mask),
      .seg_out    (seg_out),
      .an_out     (an_out),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]    seg;
      logic [ND-1:0] an;
      logic          fd;
      logic          rdy;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int fd_seen = 0;

   logic [7:0] hex_seg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Model state
   bit            m_on;
   int            m_pos;
   logic [4*ND-1:0] m_shadow, m_pend;
   bit            m_ready;
   logic [7:0]    m_seg;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit lz_blank(input logic [4*ND-1:0] v, input int dig);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      int h;
      h = -1;
      for (int i = 0; i < ND; i++) if (v[4*i +: 4] != 4'h0) h = i;
      return (dig != 0) && (dig > h);
`else
      return 1'b0;
`endif
   endfunction

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_step();
      bit   was_off, start, wrap, xfer, commit;
      int   dig, w;
      exp_t e;
      was_off = !m_on;
      start   = 1'b0;
      wrap    = 1'b0;
      if (!enable) begin
         m_on  = 1'b0;
         m_pos = 0;
      end else if (!m_on) begin
         m_on  = 1'b1;
         m_pos = 0;
         start = 1'b1;
      end else begin
         m_pos = (m_pos + 1) % FRAME;
         start = (m_pos == 0);
         wrap  = start;
      end
      xfer   = load_valid && m_ready;
      commit = !m_ready && (start || was_off);
      if (commit) m_shadow = m_pend;
      if (xfer) begin
         m_pend  = load_data;
         m_ready = 1'b0;
      end else if (commit) begin
         m_ready = 1'b1;
      end

      e.seg = 8'hFF;
      e.an  = '1;
      e.fd  = wrap;
      e.rdy = m_ready;
      if (m_on) begin
         dig = m_pos / SLOT;
         w   = m_pos % SLOT;
         if (w >= DC) begin
            if (w == DC) begin
               if (blank_mask[dig] || lz_blank(m_shadow, dig)) m_seg = 8'hFF;
               else m_seg = hex_seg[m_shadow[4*dig +: 4]];
            end
            e.seg     = m_seg;
            e.an[dig] = 1'b0;
         end
      end
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      model_step();
      #1;
      e = sb.pop_front();
      check("seg_out", 32'(seg_out), 32'(e.seg));
      check("an_out", 32'(an_out), 32'(e.an));
      check("frame_done", 32'(frame_done), 32'(e.fd));
      check("load_ready", 32'(load_ready), 32'(e.rdy));
      if (frame_done) fd_seen++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Run until the model sits at frame position p, bounded.
   task automatic wait_pos(input int p);
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 3 * FRAME; n++) begin
         if (m_on && m_pos == p) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      check("wait_pos_timeout", 32'(hit), 32'd1);
   endtask

   task automatic load_one(input logic [4*ND-1:0] v);
      bit done, pre;
      done       = 1'b0;
      load_valid = 1'b1;
      load_data  = v;
      for (int n = 0; n < 3 * FRAME; n++) begin
         pre = load_ready;
         tick();
         if (pre) begin
            done = 1'b1;
            break;
         end
      end
      load_valid = 1'b0;
      check("load_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      blank_mask = '0;
      m_on       = 1'b0;
      m_pos      = 0;
      m_shadow   = '0;
      m_pend     = '0;
      m_ready    = 1'b1;
      m_seg      = 8'hFF;

      #12;
      check("rst_seg", 32'(seg_out), 32'h0000_00FF);
      check("rst_an", 32'(an_out), 32'h0000_000F);
      check("rst_ready", 32'(load_ready), 32'd1);
      check("rst_fd", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      run(3);

      // Free-running scan of zeros; two frame_done pulses expected in 49 edges.
      enable  = 1'b1;
      fd_seen = 0;
      run(2 * FRAME + 1);
      check("fd_count", 32'(fd_seen), 32'd2);

      // Mid-frame load.
      wait_pos(8);
      load_one(16'h1A2F);
      run(2 * FRAME);

      // Back-to-back loads; the second stalls until commit.
      wait_pos(3);
      load_one(16'h1111);
      load_one(16'h2222);
      run(2 * FRAME);

      // Blank digit 2.
      blank_mask = 4'b0100;
      run(FRAME + 4);
      blank_mask = 4'b0000;

      // Disable mid-DRIVE of digit 2, then restart.
      wait_pos(2 * SLOT + DC + 1);
      enable = 1'b0;
      run(3);
      enable = 1'b1;
      run(FRAME + 2);

      // Load while idle commits directly.
      enable = 1'b0;
      run(2);
      load_one(16'h3C4D);
      run(3);
      enable = 1'b1;
      run(FRAME + 2);

      // Leading-zero patterns (only blanked with the build option).
      load_one(16'h0050);
      run(2 * FRAME);
      load_one(16'h0000);
      run(2 * FRAME);

      // Transfer on the exact commit edge.
      wait_pos(FRAME - 1);
      load_one(16'hBEEF);
      run(2 * FRAME);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=0", checks);
      $fatal(1);
   end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one 8-bit segment bus. It holds a shadow copy of NUM_DIGITS hex nibbles, loaded through a valid/ready handshake. It walks the digits at a fixed refresh rate, inserting a blanked dead-time before each digit to suppress ghosting. It sits between the system-side value producer and the board segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2).
PRESCALE, 50000, clk cycles each digit is driven (DRIVE slot length, >=2).
DEAD_CYCLES, 16, clk cycles of full blanking before each digit (>=1).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  scan enable; low forces display dark.
load_valid  in  1  load_data is valid.
load_ready  out  1  controller can accept a new value.
load_data  in  4*NUM_DIGITS  hex nibbles; [3:0] = digit 0 (least significant / rightmost).
blank_mask  in  NUM_DIGITS  bit i = 1 forces digit i blank; sampled live each slot.
seg_out  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always off (1).
an_out  out  NUM_DIGITS  active-low anode selects, at most one low at a time.
frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (async assert, sync release): state IDLE, idx=0, counter=0, shadow=0, pending empty, seg_out=8'hFF, an_out all 1, load_ready=1, frame_done=0.
- All outputs registered; seg_out and an_out change on the same edge, never skewed.
- States: IDLE, DEAD, DRIVE.
  - IDLE: an_out all 1, seg_out 8'hFF. When enable=1, next state is DEAD with idx=0 and counter=0.
  - DEAD: an_out all 1, seg_out 8'hFF, for exactly DEAD_CYCLES cycles, then DRIVE.
  - DRIVE: an_out[idx]=0 and seg_out=decode(shadow[idx]) for exactly PRESCALE cycles. If the digit is blanked, an_out[idx] is still 0 and seg_out=8'hFF. At slot end, if idx==NUM_DIGITS-1: idx wraps to 0 and frame_done pulses on the cycle DEAD is entered. Otherwise idx increments. Next state is DEAD.
  - Frame length is NUM_DIGITS*(DEAD_CYCLES+PRESCALE) cycles.
- enable low in any state: next cycle IDLE, outputs dark, idx and counter cleared. Shadow and pending are retained.
- Handshake:
  - Transfer occurs when load_valid && load_ready; load_data is captured into a pending register.
  - load_ready=0 while pending is full.
  - Pending is committed to shadow on the cycle a frame starts (entry to DEAD with idx=0, including from IDLE), so no frame shows mixed values. Pending then empties and load_ready returns to 1 on the next cycle.
  - In IDLE, pending commits on the next cycle.
  - A transfer in the same cycle as a commit: the commit uses the old pending, and the new data becomes pending.
- blank_mask is sampled at DRIVE entry and held for the slot.
- Decode: 0-F map to 8'hC0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.

Optional Feature:
- Macro: SSEG_LEADING_ZERO_BLANK_EN.
- Defined: digits above the highest nonzero nibble of shadow are blanked (OR'd with blank_mask). Digit 0 is never auto-blanked, so value 0 shows a single "0".
- Undefined: only blank_mask blanks digits; all zeros are displayed.

Decomposition:
- Package sseg_pkg: SEG_BLANK=8'hFF; the 16-entry hex-to-segment constant table; scan state enum {IDLE, DEAD, DRIVE}.
- Sub-module sseg_decode: combinational nibble + blank -> 8-bit pattern, instantiated once on the selected nibble.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=4, DEAD_CYCLES=2.
- Reset then enable=1 with shadow 0: after 2 dark cycles, an_out=4'b1110 and seg_out=8'hC0 for 4 cycles, then 2 dark. Sequence repeats for digits 1..3. frame_done pulses once every 24 cycles.
- Load 16'h1A2F while mid-frame: display unchanged until the next frame start, then digits 0..3 show 8E, A4, 88, F9. load_ready is low from transfer until the cycle after the commit.
- Back-to-back loads 16'h1111 then 16'h2222 within one frame: the second stalls (load_ready=0) until commit. The next frame shows 1111, the following frame 2222.
- blank_mask=4'b0100: during digit 2 DRIVE, an_out=4'b1011 and seg_out=8'hFF. Other digits are normal.
- Deassert enable mid-DRIVE of digit 2: next cycle an_out=4'hF and seg_out=8'hFF. Re-enable restarts at digit 0 after 2 dead cycles.
- With SSEG_LEADING_ZERO_BLANK_EN, load 16'h0050: digits 3 and 2 blank, digit 1 shows 8'h92, digit 0 shows 8'hC0. Load 16'h0000: only digit 0 is lit, showing 8'hC0.
